dram_maint_sched: RTL and testbench

- Maintenance scheduler for the DDR3 MIG user-maintenance interface.
- Issues periodic refresh and ZQ-calibration requests, and sequences software-requested self-refresh entry and exit.
- Tracks outstanding AXI transactions and gates new AW/AR traffic while draining for self-refresh.
- Sits in the DRAM AXI clock domain, beside the final spill stage in front of the memory controller.

---
 rtl/dram_maint_sched_if.sv | 28 ++
 rtl/dram_maint_sched.sv | 278 +++++++++++++++++++++++++++
 tb/tb_dram_maint_sched.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_maint_sched_if.sv
// dram_maint_sched_if
// Groups the MIG user-maintenance handshake signals seen by the scheduler.
//   calib_done : MIG init_calib_complete
//   ref_req    : app_ref_req  / ref_ack   : app_ref_ack
//   zq_req     : app_zq_req   / zq_ack    : app_zq_ack
//   sr_req     : app_sr_req   / sr_active : app_sr_active
// Modports:
//   master : scheduler side (drives the requests, observes acks/status)
//   slave  : MIG side (drives acks/status, observes the requests)
interface dram_maint_sched_if;
  logic calib_done;
  logic ref_req;
  logic ref_ack;
  logic zq_req;
  logic zq_ack;
  logic sr_req;
  logic sr_active;

  modport master (
    input  calib_done, ref_ack, zq_ack, sr_active,
    output ref_req, zq_req, sr_req
  );

  modport slave (
    output calib_done, ref_ack, zq_ack, sr_active,
    input  ref_req, zq_req, sr_req
  );
endinterface

// File: rtl/dram_maint_sched.sv
// dram_maint_sched
// Maintenance scheduler for the DDR3 MIG user-maintenance interface. Issues
// periodic refresh and ZQ-calibration requests, sequences software-requested
// self-refresh entry/exit, and tracks outstanding AXI transactions so new
// AW/AR traffic can be gated while draining for self-refresh.
//
// Ports:
//   clk_i, rst_ni       : DRAM AXI clock, synchronous active-low reset
//   mig                 : MIG maintenance handshake (dram_maint_sched_if.master)
//   sr_enter_i/exit_i   : one-cycle self-refresh entry / exit requests
//   aw/ar/b/r_last_hs_i : handshake strobes observed at the MIG AXI port
//   gate_o              : upstream must hold AW/AR valid low while set
//   busy_o              : FSM is neither IDLE nor INIT
//   outst_o             : outstanding-transaction count
//   ref_pend_o          : postponed refresh count
//   state_o             : encoded FSM state
//   err_o               : sticky ack-timeout error
//
// Optional feature: define DRAM_MAINT_TIMEOUT_EN to bound every ack wait to
// AckTimeout cycles. Without it the waits are unbounded and err_o is 0.
module dram_maint_sched #(
  parameter int unsigned RefInterval = 1560,
  parameter int unsigned ZqInterval  = 20000000,
  parameter int unsigned OutstWidth  = 8,
  parameter int unsigned MaxRefPend  = 8,
  parameter int unsigned AckTimeout  = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  dram_maint_sched_if.master    mig,
  input  logic                  sr_enter_i,
  input  logic                  sr_exit_i,
  input  logic                  aw_hs_i,
  input  logic                  ar_hs_i,
  input  logic                  b_hs_i,
  input  logic                  r_last_hs_i,
  output logic                  gate_o,
  output logic                  busy_o,
  output logic [OutstWidth-1:0] outst_o,
  output logic [3:0]            ref_pend_o,
  output logic [2:0]            state_o,
  output logic                  err_o
);

  if (RefInterval < 2) begin : g_bad_ref_interval
    $error("dram_maint_sched: RefInterval must be >= 2");
  end
  if (ZqInterval < 2) begin : g_bad_zq_interval
    $error("dram_maint_sched: ZqInterval must be >= 2");
  end
  if (MaxRefPend > 15) begin : g_bad_max_ref_pend
    $error("dram_maint_sched: MaxRefPend must be <= 15");
  end
  if (AckTimeout < 1) begin : g_bad_ack_timeout
    $error("dram_maint_sched: AckTimeout must be >= 1");
  end

  localparam int unsigned RefW = $clog2(RefInterval);
  localparam int unsigned ZqW  = $clog2(ZqInterval);
  localparam int unsigned SumW = OutstWidth + 2;

  localparam logic [RefW-1:0]       RefReload  = RefW'(RefInterval - 1);
  localparam logic [ZqW-1:0]        ZqReload   = ZqW'(ZqInterval - 1);
  localparam logic [3:0]            RefPendMax = 4'(MaxRefPend);
  localparam logic [OutstWidth-1:0] OutstMax   = '1;
  localparam logic [OutstWidth-1:0] OutstHigh  = OutstMax - 1'b1;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    REF     = 3'd2,
    ZQ      = 3'd3,
    DRAIN   = 3'd4,
    SR_REQ  = 3'd5,
    SR_ACT  = 3'd6,
    SR_EXIT = 3'd7
  } state_e;

  state_e                  state_q, state_d;
  logic [RefW-1:0]         ref_cnt_q;
  logic [ZqW-1:0]          zq_cnt_q;
  logic [3:0]              ref_pend_q;
  logic                    zq_pend_q;
  logic                    sr_pend_q;
  logic [OutstWidth-1:0]   outst_q;

  logic counting, reload;
  logic ref_tick, zq_tick;
  logic ref_done, zq_done, sr_flush;
  logic ack_timeout;
  logic ref_req, zq_req, sr_req, fsm_gate;

  // Interval counters only run while the controller is in normal operation.
  assign counting = state_q inside {IDLE, REF, ZQ};
  assign ref_tick = counting && (ref_cnt_q == '0);
  assign zq_tick  = counting && (zq_cnt_q == '0);
  assign reload   = (state_q inside {INIT, SR_EXIT}) && (state_d == IDLE);

  // A timed-out wait retires the pending work exactly like an ack would.
  assign ref_done = (state_q == REF) && (mig.ref_ack || ack_timeout);
  assign zq_done  = (state_q == ZQ)  && (mig.zq_ack  || ack_timeout);
  assign sr_flush = (state_q == SR_REQ) && mig.sr_active;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // IDLE looks at this cycle's ticks as well as the stored pending state so
  // a refresh request goes out the cycle after its tick.
  always_comb begin
    state_d  = state_q;
    ref_req  = 1'b0;
    zq_req   = 1'b0;
    sr_req   = 1'b0;
    fsm_gate = 1'b0;
    case (state_q)
      INIT: begin
        if (mig.calib_done) state_d = IDLE;
      end
      IDLE: begin
        if (ref_pend_q != '0 || ref_tick)  state_d = REF;
        else if (zq_pend_q || zq_tick)     state_d = ZQ;
        else if (sr_pend_q)                state_d = DRAIN;
      end
      REF: begin
        ref_req = 1'b1;
        if (mig.ref_ack || ack_timeout) state_d = IDLE;
      end
      ZQ: begin
        zq_req = 1'b1;
        if (mig.zq_ack || ack_timeout) state_d = IDLE;
      end
      DRAIN: begin
        fsm_gate = 1'b1;
        if (outst_q == '0) state_d = SR_REQ;
      end
      SR_REQ: begin
        sr_req   = 1'b1;
        fsm_gate = 1'b1;
        if (mig.sr_active)     state_d = SR_ACT;
        else if (ack_timeout)  state_d = IDLE;
      end
      SR_ACT: begin
        sr_req   = 1'b1;
        fsm_gate = 1'b1;
        if (sr_exit_i) state_d = SR_EXIT;
      end
      SR_EXIT: begin
        fsm_gate = 1'b1;
        if (!mig.sr_active || ack_timeout) state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ref_cnt_q <= '0;
      zq_cnt_q  <= '0;
    end else if (reload) begin
      ref_cnt_q <= RefReload;
      zq_cnt_q  <= ZqReload;
    end else if (counting) begin
      ref_cnt_q <= ref_tick ? RefReload : ref_cnt_q - 1'b1;
      zq_cnt_q  <= zq_tick  ? ZqReload  : zq_cnt_q  - 1'b1;
    end
  end

  // A tick and an ack in the same cycle cancel; the count saturates so
  // postponed refreshes beyond MaxRefPend are dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ref_pend_q <= '0;
    end else if (sr_flush) begin
      ref_pend_q <= '0;
    end else if (ref_tick && !ref_done) begin
      if (ref_pend_q != RefPendMax) ref_pend_q <= ref_pend_q + 1'b1;
    end else if (!ref_tick && ref_done) begin
      if (ref_pend_q != '0) ref_pend_q <= ref_pend_q - 1'b1;
    end
  end

  // A new ZQ tick wins over a same-cycle ack: the ack belongs to the old one.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      zq_pend_q <= 1'b0;
    end else if (sr_flush) begin
      zq_pend_q <= 1'b0;
    end else if (zq_tick) begin
      zq_pend_q <= 1'b1;
    end else if (zq_done) begin
      zq_pend_q <= 1'b0;
    end
  end

  // Entry requests are ignored once the self-refresh sequence has started.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_pend_q <= 1'b0;
    end else if (state_q == IDLE && state_d == DRAIN) begin
      sr_pend_q <= 1'b0;
    end else if (sr_enter_i && (state_q inside {INIT, IDLE, REF, ZQ})) begin
      sr_pend_q <= 1'b1;
    end
  end

  // Up to two increments and two decrements can land together; the sum is
  // formed two bits wider and clamped to the counter range.
  logic [SumW-1:0] outst_up, outst_dn, outst_sum;
  always_comb begin
    outst_up  = {2'b00, outst_q} + SumW'(aw_hs_i) + SumW'(ar_hs_i);
    outst_dn  = SumW'(b_hs_i) + SumW'(r_last_hs_i);
    outst_sum = '0;
    if (outst_up > outst_dn) outst_sum = outst_up - outst_dn;
    if (outst_sum > SumW'(OutstMax)) outst_sum = SumW'(OutstMax);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      outst_q <= '0;
    end else begin
      outst_q <= outst_sum[OutstWidth-1:0];
    end
  end

`ifdef DRAM_MAINT_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(AckTimeout + 1);

  logic [ToW-1:0] to_cnt_q;
  logic           err_q;
  logic           waiting, wait_met;

  assign waiting  = state_q inside {REF, ZQ, SR_REQ, SR_EXIT};
  assign wait_met = ((state_q == REF)     && mig.ref_ack)   ||
                    ((state_q == ZQ)      && mig.zq_ack)    ||
                    ((state_q == SR_REQ)  && mig.sr_active) ||
                    ((state_q == SR_EXIT) && !mig.sr_active);
  assign ack_timeout = waiting && !wait_met && (to_cnt_q == ToW'(AckTimeout - 1));

  // The wait counter restarts on every state change, so each request gets
  // a fresh AckTimeout-cycle window starting at its entry cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        to_cnt_q <= '0;
      end else if (waiting) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      if (ack_timeout) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign ack_timeout = 1'b0;
  assign err_o       = 1'b0;
`endif

  assign mig.ref_req = ref_req;
  assign mig.zq_req  = zq_req;
  assign mig.sr_req  = sr_req;

  // Two handshakes can land in one cycle, so gate one step before full.
  assign gate_o     = fsm_gate || (outst_q >= OutstHigh);
  // INIT is reported as not busy so every output reads 0 out of reset.
  assign busy_o     = !(state_q inside {INIT, IDLE});
  assign outst_o    = outst_q;
  assign ref_pend_o = ref_pend_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_dram_maint_sched.sv
// tb_dram_maint_sched
// Directed bench for dram_maint_sched. Main instance: RefInterval=16,
// OutstWidth=3. A second instance (ZqInterval=40, AckTimeout=8) covers the
// ZQ handshake, and its timeout path when DRAM_MAINT_TIMEOUT_EN is defined.
module tb_dram_maint_sched;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       sr_enter = 1'b0, sr_exit = 1'b0;
  logic       aw_hs = 1'b0, ar_hs = 1'b0, b_hs = 1'b0, r_last_hs = 1'b0;
  logic       gate, busy, err;
  logic [2:0] outst;
  logic [3:0] ref_pend;
  logic [2:0] state;

  logic       z_gate, z_busy, z_err;
  logic [7:0] z_outst;
  logic [3:0] z_ref_pend;
  logic [2:0] z_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic auto_ack = 1'b0;

  dram_maint_sched_if mig ();
  dram_maint_sched_if zmig ();

  dram_maint_sched #(
    .RefInterval(16), .ZqInterval(1000000), .OutstWidth(3),
    .MaxRefPend(8), .AckTimeout(1024)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .mig(mig.master),
    .sr_enter_i(sr_enter), .sr_exit_i(sr_exit),
    .aw_hs_i(aw_hs), .ar_hs_i(ar_hs), .b_hs_i(b_hs), .r_last_hs_i(r_last_hs),
    .gate_o(gate), .busy_o(busy), .outst_o(outst), .ref_pend_o(ref_pend),
    .state_o(state), .err_o(err)
  );

  dram_maint_sched #(
    .RefInterval(4000), .ZqInterval(40), .OutstWidth(8),
    .MaxRefPend(8), .AckTimeout(8)
  ) u_zq (
    .clk_i(clk), .rst_ni(rst_ni), .mig(zmig.master),
    .sr_enter_i(1'b0), .sr_exit_i(1'b0),
    .aw_hs_i(1'b0), .ar_hs_i(1'b0), .b_hs_i(1'b0), .r_last_hs_i(1'b0),
    .gate_o(z_gate), .busy_o(z_busy), .outst_o(z_outst), .ref_pend_o(z_ref_pend),
    .state_o(z_state), .err_o(z_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       aw, ar, b, r;
    logic [2:0] exp_outst;
    logic       exp_gate;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic aw, ar, b, r, input logic [2:0] o, input logic g);
    vec_t v;
    v.aw = aw; v.ar = ar; v.b = b; v.r = r; v.exp_outst = o; v.exp_gate = g;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (auto_ack) mig.ref_ack = mig.ref_req;
  endtask

  task automatic applyStimulus(input logic aw, ar, b, r);
    aw_hs = aw; ar_hs = ar; b_hs = b; r_last_hs = r;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rise, hi_cnt, n, t0;
    logic found, saw_drain;

    // outstanding-counter vectors, starting from outst=0
    for (int i = 0; i < 5; i++) addVec(1, 0, 0, 0, 3'(i + 1), 0);
    addVec(1, 0, 0, 0, 6, 1);
    addVec(1, 0, 0, 0, 7, 1);
    addVec(1, 1, 0, 0, 7, 1);
    addVec(0, 0, 1, 0, 6, 1);
    addVec(0, 0, 1, 1, 4, 0);
    addVec(0, 0, 0, 1, 3, 0);
    addVec(1, 1, 1, 0, 4, 0);
    addVec(1, 0, 0, 0, 5, 0);
    for (int i = 0; i < 10; i++) addVec(1, 1, 1, 1, 5, 0);
    addVec(0, 0, 1, 1, 3, 0);
    addVec(0, 0, 1, 1, 1, 0);
    addVec(0, 0, 1, 1, 0, 0);
    addVec(0, 0, 0, 1, 0, 0);
    addVec(1, 0, 1, 1, 0, 0);
    addVec(0, 1, 0, 0, 1, 0);
    addVec(1, 1, 1, 1, 1, 0);
    addVec(0, 0, 1, 0, 0, 0);

    mig.calib_done = 1'b0; mig.ref_ack = 1'b0; mig.zq_ack = 1'b0; mig.sr_active = 1'b0;
    zmig.calib_done = 1'b0; zmig.ref_ack = 1'b0; zmig.zq_ack = 1'b0; zmig.sr_active = 1'b0;

    $display("[TB] reset");
    repeat (3) step();
    rst_ni = 1'b1;
    cyc = 0;
    checkOutput("rst_state", state, 0);
    checkOutput("rst_ref_req", mig.ref_req, 0);
    checkOutput("rst_zq_req", mig.zq_req, 0);
    checkOutput("rst_sr_req", mig.sr_req, 0);
    checkOutput("rst_gate", gate, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_outst", outst, 0);
    checkOutput("rst_ref_pend", ref_pend, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_z_state", z_state, 0);

    // calib at cycle 5 -> first refresh request at cycle 22
    $display("[TB] first refresh");
    while (cyc < 5) step();
    checkOutput("init_hold_state", state, 0);
    mig.calib_done = 1'b1;
    step();
    checkOutput("calib_idle_state", state, 1);
    while (!mig.ref_req && cyc < 60) step();
    rise = cyc;
    checkOutput("first_ref_rise_cycle", rise, 22);
    checkOutput("first_ref_pend", ref_pend, 1);
    checkOutput("first_ref_busy", busy, 1);
    hi_cnt = 1;
    repeat (3) begin
      step();
      if (mig.ref_req) hi_cnt++;
    end
    mig.ref_ack = 1'b1;
    step();
    mig.ref_ack = 1'b0;
    if (mig.ref_req) hi_cnt++;
    checkOutput("ref_req_high_cycles", hi_cnt, 4);
    checkOutput("ref_req_dropped", mig.ref_req, 0);
    checkOutput("ref_pend_after_ack", ref_pend, 0);
    checkOutput("ref_back_idle", state, 1);

    // no acks for 200 cycles: pending count saturates, request held
    $display("[TB] refresh saturation");
    repeat (200) step();
    checkOutput("sat_ref_pend", ref_pend, 8);
    checkOutput("sat_ref_req", mig.ref_req, 1);
    checkOutput("sat_state", state, 2);
    checkOutput("sat_err", err, 0);

    auto_ack = 1'b1;
    mig.ref_ack = mig.ref_req;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (state == 3'd1 && ref_pend == 4'd0) found = 1'b1;
    end
    checkOutput("ref_backlog_drained", found, 1);

    // calib_done dropping after INIT is ignored
    mig.calib_done = 1'b0;
    repeat (3) step();
    checkOutput("calib_fall_not_init", state != 3'd0, 1);
    mig.calib_done = 1'b1;

    // table-driven outstanding counter / gate vectors
    $display("[TB] outstanding table (%0d vectors)", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].aw, vecs[i].ar, vecs[i].b, vecs[i].r);
      step();
      checkOutput($sformatf("vec%0d_outst", i), outst, vecs[i].exp_outst);
      checkOutput($sformatf("vec%0d_gate", i), gate, vecs[i].exp_gate);
    end
    applyStimulus(0, 0, 0, 0);

    // self-refresh with three transactions outstanding
    $display("[TB] self-refresh");
    applyStimulus(1, 0, 0, 0);
    repeat (3) step();
    applyStimulus(0, 0, 0, 0);
    checkOutput("sr_pre_outst", outst, 3);
    sr_enter = 1'b1;
    step();
    sr_enter = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (state == 3'd4) found = 1'b1;
      else step();
    end
    checkOutput("sr_reach_drain", found, 1);
    checkOutput("drain_gate", gate, 1);
    checkOutput("drain_sr_req", mig.sr_req, 0);
    applyStimulus(0, 0, 1, 0);
    step();
    checkOutput("drain1_state", state, 4);
    applyStimulus(0, 0, 0, 1);
    step();
    checkOutput("drain2_sr_req", mig.sr_req, 0);
    applyStimulus(0, 0, 1, 0);
    step();
    applyStimulus(0, 0, 0, 0);
    checkOutput("drain3_outst", outst, 0);
    checkOutput("drain3_state", state, 4);
    step();
    checkOutput("sr_req_state", state, 5);
    checkOutput("sr_req_high", mig.sr_req, 1);
    checkOutput("sr_req_gate", gate, 1);
    sr_exit = 1'b1;
    step();
    sr_exit = 1'b0;
    checkOutput("early_exit_ignored", state, 5);
    mig.sr_active = 1'b1;
    step();
    checkOutput("sr_act_state", state, 6);
    checkOutput("sr_act_req", mig.sr_req, 1);
    checkOutput("sr_act_ref_pend", ref_pend, 0);
    sr_enter = 1'b1;
    step();
    sr_enter = 1'b0;
    checkOutput("sr_act_enter_ignored", state, 6);
    sr_exit = 1'b1;
    step();
    sr_exit = 1'b0;
    checkOutput("sr_exit_state", state, 7);
    checkOutput("sr_exit_req", mig.sr_req, 0);
    checkOutput("sr_exit_gate", gate, 1);
    step();
    checkOutput("sr_exit_wait_active", state, 7);
    mig.sr_active = 1'b0;
    step();
    checkOutput("sr_done_idle", state, 1);
    checkOutput("sr_done_gate", gate, 0);
    checkOutput("sr_done_busy", busy, 0);
    n = 0;
    saw_drain = 1'b0;
    while (!mig.ref_req && n < 40) begin
      step();
      n++;
      if (state == 3'd4) saw_drain = 1'b1;
    end
    checkOutput("ref_after_sr_reload", n, 16);
    checkOutput("no_stale_sr_enter", saw_drain, 0);

    // ZQ handshake on the second instance: tick 41 cycles after calib
    $display("[TB] zq handshake");
    zmig.calib_done = 1'b1;
    t0 = cyc;
    while (!zmig.zq_req && (cyc - t0) < 80) step();
    checkOutput("zq_first_rise", cyc - t0, 41);
    checkOutput("zq_state", z_state, 3);
`ifdef DRAM_MAINT_TIMEOUT_EN
    hi_cnt = 1;
    for (int i = 0; i < 30 && zmig.zq_req; i++) begin
      step();
      if (zmig.zq_req) hi_cnt++;
    end
    checkOutput("zq_timeout_high_cycles", hi_cnt, 8);
    checkOutput("zq_timeout_req", zmig.zq_req, 0);
    checkOutput("zq_timeout_err", z_err, 1);
    checkOutput("zq_timeout_idle", z_state, 1);
`else
    repeat (2) step();
    checkOutput("zq_req_held", zmig.zq_req, 1);
    zmig.zq_ack = 1'b1;
    step();
    zmig.zq_ack = 1'b0;
    checkOutput("zq_req_dropped", zmig.zq_req, 0);
    checkOutput("zq_back_idle", z_state, 1);
    step();
    checkOutput("zq_flag_cleared", z_state, 1);
    checkOutput("zq_err_tied", z_err, 0);
`endif
    checkOutput("main_err_clear", err, 0);

    // reset in the middle of a refresh handshake
    $display("[TB] reset mid-handshake");
    auto_ack = 1'b0;
    mig.ref_ack = 1'b0;
    step();
    while (!mig.ref_req && n < 200) begin
      step();
      n++;
    end
    checkOutput("mid_ref_req_up", mig.ref_req, 1);
    step();
    rst_ni = 1'b0;
    step();
    checkOutput("mid_rst_ref_req", mig.ref_req, 0);
    checkOutput("mid_rst_state", state, 0);
    checkOutput("mid_rst_ref_pend", ref_pend, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_z_state", z_state, 0);
    checkOutput("mid_rst_z_err", z_err, 0);
    rst_ni = 1'b1;
    step();
    checkOutput("post_rst_idle", state, 1);
    repeat (3) step();
    checkOutput("post_rst_no_req", mig.ref_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
